// File: rtl/alu_arb_seq.sv
// Two-requester front end for an external ALU: arbitrates, issues one op,
// captures flags and result, then holds the response until the consumer takes it.
module alu_arb_seq #(
   parameter bit         RR_EN   = 1'b1,
   parameter logic [3:0] IDLE_OP = 4'b0010
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req0_valid,
   output logic       req0_ready,
   input  logic [7:0] req0_a,
   input  logic [7:0] req0_b,
   input  logic [3:0] req0_op,
   input  logic       req1_valid,
   output logic       req1_ready,
   input  logic [7:0] req1_a,
   input  logic [7:0] req1_b,
   input  logic [3:0] req1_op,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic       rsp_id,
   output logic [7:0] rsp_data,
   output logic [2:0] rsp_flags,
   output logic       rsp_err,
   output logic [7:0] alu_a,
   output logic [7:0] alu_b,
   output logic [3:0] alu_s,
   input  logic [7:0] alu_f,
   input  logic       alu_z,
   input  logic       alu_c,
   input  logic       alu_v,
   output logic       busy
);

   localparam int unsigned DW  = 8;
   localparam int unsigned OPW = 4;
   localparam int unsigned FW  = 3;

   typedef enum logic [1:0] {IDLE, ISSUE, CAPT, RESP} state_t;

   state_t           state_q, state_d;
   logic             last_q, last_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic             rsp_id_q, rsp_id_d;
   logic [DW-1:0]    rsp_data_q, rsp_data_d;
   logic [FW-1:0]    rsp_flags_q, rsp_flags_d;
   logic             rsp_err_q, rsp_err_d;
   logic [DW-1:0]    alu_a_q, alu_a_d;
   logic [DW-1:0]    alu_b_q, alu_b_d;
   logic [OPW-1:0]   alu_s_q, alu_s_d;
   logic             busy_q, busy_d;

   logic             gnt0_c, gnt1_c;
   logic [DW-1:0]    sel_a_c, sel_b_c;
   logic [OPW-1:0]   sel_op_c;

   // Grant only in IDLE and out of reset; last_q=1 means requester 1 won last.
   always_comb begin
      gnt0_c = 1'b0;
      gnt1_c = 1'b0;
      if (rst && state_q == IDLE) begin
         if (req0_valid && req1_valid) begin
            if (RR_EN && !last_q) gnt1_c = 1'b1;
            else                  gnt0_c = 1'b1;
         end else begin
            gnt0_c = req0_valid;
            gnt1_c = req1_valid;
         end
      end
      sel_a_c  = gnt1_c ? req1_a  : req0_a;
      sel_b_c  = gnt1_c ? req1_b  : req0_b;
      sel_op_c = gnt1_c ? req1_op : req0_op;
   end

   // Next state and next registered outputs.
   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      rsp_valid_d = rsp_valid_q;
      rsp_id_d    = rsp_id_q;
      rsp_data_d  = rsp_data_q;
      rsp_flags_d = rsp_flags_q;
      rsp_err_d   = rsp_err_q;
      alu_a_d     = DW'(0);
      alu_b_d     = DW'(0);
      alu_s_d     = IDLE_OP;
      case (state_q)
         IDLE: begin
            if (gnt0_c || gnt1_c) begin
               last_d   = gnt1_c;
               rsp_id_d = gnt1_c;
               if (sel_op_c[1:0] == 2'b10) begin
                  // Hold codes are rejected without touching the ALU.
                  state_d     = RESP;
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b1;
                  rsp_data_d  = DW'(0);
                  rsp_flags_d = FW'(0);
               end else begin
                  state_d   = ISSUE;
                  rsp_err_d = 1'b0;
                  alu_a_d   = sel_a_c;
                  alu_b_d   = sel_b_c;
                  alu_s_d   = sel_op_c;
               end
            end
         end
         ISSUE: begin
            rsp_flags_d = {alu_z, alu_c, alu_v};
            state_d     = CAPT;
         end
         CAPT: begin
            rsp_data_d  = alu_f;
            rsp_valid_d = 1'b1;
            state_d     = RESP;
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= IDLE;
         last_q      <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= 1'b0;
         rsp_data_q  <= DW'(0);
         rsp_flags_q <= FW'(0);
         rsp_err_q   <= 1'b0;
         alu_a_q     <= DW'(0);
         alu_b_q     <= DW'(0);
         alu_s_q     <= IDLE_OP;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_data_q  <= rsp_data_d;
         rsp_flags_q <= rsp_flags_d;
         rsp_err_q   <= rsp_err_d;
         alu_a_q     <= alu_a_d;
         alu_b_q     <= alu_b_d;
         alu_s_q     <= alu_s_d;
         busy_q      <= busy_d;
      end
   end

   // rsp_valid is masked while reset is held so nothing is offered mid-reset.
   assign req0_ready = gnt0_c;
   assign req1_ready = gnt1_c;
   assign rsp_valid  = rsp_valid_q & rst;
   assign rsp_id     = rsp_id_q;
   assign rsp_data   = rsp_data_q;
   assign rsp_flags  = rsp_flags_q;
   assign rsp_err    = rsp_err_q;
   assign alu_a      = alu_a_q;
   assign alu_b      = alu_b_q;
   assign alu_s      = alu_s_q;
   assign busy       = busy_q;

endmodule

// File: doc/alu_arb_seq.md
ALU_ARB_SEQ -- requirements
Module: alu_arb_seq

Interface
REQ-001 Parameter RR_EN, default 1: 1 selects round-robin arbitration; 0 gives requester 0 fixed priority.
REQ-002 Parameter IDLE_OP, default 4'b0010: op driven on alu_s whenever no operation issues; it is an ALU hold code.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-low reset.
REQ-005 req0_valid / req1_valid  input  1  requester N presents an operation.
REQ-006 req0_ready / req1_ready  output  1  operation from requester N is accepted this cycle.
REQ-007 req0_a, req0_b / req1_a, req1_b  input  8  operands.
REQ-008 req0_op / req1_op  input  4  ALU select code.
REQ-009 rsp_valid  output  1  response available.
REQ-010 rsp_ready  input  1  consumer takes the response.
REQ-011 rsp_id  output  1  requester that owns the response.
REQ-012 rsp_data  output  8  ALU result.
REQ-013 rsp_flags  output  3  {Z,C,V} captured at issue.
REQ-014 rsp_err  output  1  operation was rejected and not executed.
REQ-015 alu_a, alu_b  output  8  operands to the ALU.
REQ-016 alu_s  output  4  select code to the ALU.
REQ-017 alu_f  input  8  registered ALU result.
REQ-018 alu_z, alu_c, alu_v  input  1  combinational ALU flags.
REQ-019 busy  output  1  high in any state other than IDLE.

Function
REQ-020 FSM states SHALL be IDLE, ISSUE, CAPT and RESP.
REQ-021 IDLE: if any reqN_valid is high, assert the granted reqN_ready for that cycle only, latch a, b, op and id, then go to ISSUE.
REQ-022 Only one ready SHALL be high per cycle; in any state other than IDLE, both readies are low.
REQ-023 RR_EN=1, both valid: grant the requester not granted last; after reset, requester 0 wins first.
REQ-024 RR_EN=0, both valid: requester 0 always wins.
REQ-025 Hold codes are op[1:0]==2'b10.
  - A latched hold code skips ISSUE and CAPT and goes directly to RESP.
  - Response: rsp_err=1, rsp_data=8'h00, rsp_flags=3'b000.
REQ-026 ISSUE (exactly one cycle):
  - alu_a, alu_b, alu_s = latched values.
  - Sample {alu_z, alu_c, alu_v} into the flags register at the clock edge.
  - Next state CAPT.
REQ-027 CAPT (one cycle):
  - alu_s = IDLE_OP.
  - Sample alu_f into the data register.
  - Next state RESP.
REQ-028 RESP:
  - rsp_valid=1; rsp_id, rsp_data, rsp_flags and rsp_err stable until the handshake.
  - Next state IDLE on rsp_valid && rsp_ready.
REQ-029 Latency: acceptance edge to rsp_valid high is 3 cycles for a normal op and 1 cycle for a rejected op.
REQ-030 A new operation can be accepted no earlier than the cycle after the response handshake; there is no back-to-back overlap.
REQ-031 Outside ISSUE: alu_s = IDLE_OP and alu_a = alu_b = 8'h00.
REQ-032 Requester inputs SHALL be ignored when reqN_ready is low; changes after acceptance do not affect the operation in flight.
REQ-033 rsp_ready held high with no response pending has no effect.

Reset
REQ-034 rst low at a clock edge SHALL force IDLE from any state, aborting any operation in flight with no response.
REQ-035 Reset values: rsp_valid=0, rsp_id=0, rsp_data=8'h00, rsp_flags=3'b000, rsp_err=0, req0_ready=req1_ready=0, busy=0, alu_a=alu_b=8'h00, alu_s=IDLE_OP, round-robin pointer favours requester 0.
REQ-036 While rst is low, all readies and rsp_valid SHALL remain 0 regardless of the inputs.

Verification
REQ-037 Single op: req0 a=8'h05, b=8'h03, arithmetic add code, rsp_ready=1.
  - alu_s shows the op for exactly one cycle.
  - rsp_valid 3 cycles after acceptance; rsp_id=0, rsp_data equals alu_f from the CAPT edge, rsp_err=0.
REQ-038 Contention, RR_EN=1: both valid continuously for 4 ops.
  - Grant order 0,1,0,1; never two readies high in the same cycle.
REQ-039 Contention, RR_EN=0: both valid for 3 ops.
  - All grants go to requester 0; requester 1 is granted only after req0_valid drops.
REQ-040 Rejected op: req1_op=4'b0010 and then 4'b1110.
  - Each gives rsp_err=1, rsp_data=8'h00, rsp_id=1 one cycle after acceptance; alu_s stays IDLE_OP throughout.
REQ-041 Backpressure: rsp_ready=0 for 5 cycles in RESP.
  - Response fields stable and busy=1; req0_valid stays un-readied; IDLE is re-entered the cycle after rsp_ready=1.
REQ-042 Reset mid-operation: rst=0 in ISSUE, then in RESP.
  - Next cycle: IDLE, rsp_valid=0, all outputs at reset values, and no response is ever delivered for the aborted op.
